skip_concat: RTL and testbench

- Sits directly downstream of the decoder deconvolution stage (string2matrix → conv → ReLu → up_sampling).
- Merges the up-sampled activation stream (stream A) with the skip-connection feature map streamed from DDR as 64-bit words (stream B).
- Emits one pixel-serial stream per pixel: CHAN_A samples from A, then CHAN_B samples from B.
- Regenerates sop/eop/sof/eof for the concatenated stream and requests DDR refills through ddr_fifo_aempty.

---
 rtl/skip_concat_pkg.sv | 30 +++
 rtl/sync_fifo_sa.sv | 67 ++++++
 rtl/skip_concat.sv | 236 +++++++++++++++++++++++
 tb/tb_skip_concat.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skip_concat_pkg.sv
// skip_concat_pkg: shared types and sizing helpers for the skip-connection
// concatenation block (skip_concat) and its showahead FIFO (sync_fifo_sa).
package skip_concat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2,
    WAIT   = 2'd3
  } state_e;

  // Skip words arrive from DDR as 64-bit words of byte-wide samples.
  localparam int BYTES_PER_WORD = 8;

  // Counter width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default geometry and the counter widths that follow from it.
  localparam int DEF_STRING_LEN = 224;
  localparam int DEF_LINE_NUM   = 224;
  localparam int DEF_CHAN_A     = 16;
  localparam int DEF_CHAN_B     = 16;
  localparam int DEF_PIX_W      = clog2w(DEF_STRING_LEN);
  localparam int DEF_LINE_W     = clog2w(DEF_LINE_NUM);
  localparam int DEF_CHA_W      = clog2w(DEF_CHAN_A);
  localparam int DEF_CHB_W      = clog2w(DEF_CHAN_B);

endpackage

// File: rtl/sync_fifo_sa.sv
// sync_fifo_sa: single-clock showahead FIFO with occupancy count.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write din_i (accepted if not full, or if popping this cycle)
//   pop_i      : consume the head; ignored when empty
//   dout_o     : head entry, valid whenever count_o != 0
//   count_o    : entries held
//   drop_o     : push rejected this cycle because the FIFO was full
module sync_fifo_sa
  import skip_concat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = clog2w(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o
);
  localparam int PW = clog2w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop, do_push;

  // A pop in the same cycle frees the slot the push needs.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign drop_o  = push_i && !do_push;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d  = do_pop  ? nxt(rd_q) : rd_q;
    wr_d  = do_push ? nxt(wr_q) : wr_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/skip_concat.sv
// skip_concat: concatenates the up-sampled activation stream (A) with the
// DDR skip feature map (B) into one pixel-serial stream: CHAN_A samples
// from A followed by CHAN_B bytes from B per pixel, with sop/eop/sof/eof
// regenerated from internal pixel/line counters.
//   clk, reset                 : clock, synchronous active-high reset
//   data_i, data_valid_i, sof_i: stream A sample, strobe, frame-start tag
//   sop_i, eop_i, eof_i        : accepted but unused (framing is rebuilt)
//   ddr_data, ddr_data_valid   : 64-bit skip word, byte 0 = [7:0] first
//   ddr_fifo_aempty            : registered refill request to DDR reader
//   data_o, data_valid_o       : registered concatenated sample
//   sop_o, eop_o, sof_o, eof_o : regenerated framing
//   a_ovf_o, b_ovf_o           : sticky FIFO overflow flags
module skip_concat
  import skip_concat_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHAN_A     = DEF_CHAN_A,
  parameter int CHAN_B     = DEF_CHAN_B,
  parameter int STRING_LEN = DEF_STRING_LEN,
  parameter int LINE_NUM   = DEF_LINE_NUM,
  parameter int A_DEPTH    = 64,
  parameter int B_DEPTH    = 64,
  parameter int AEMPTY_THR = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  input  logic [63:0]           ddr_data,
  input  logic                  ddr_data_valid,
  output logic                  ddr_fifo_aempty,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  a_ovf_o,
  output logic                  b_ovf_o
);
  localparam int ACW    = clog2w(A_DEPTH + 1);
  localparam int BCW    = clog2w(B_DEPTH + 1);
  localparam int CNT_W  = clog2w((CHAN_A > CHAN_B) ? CHAN_A : CHAN_B);
  localparam int PIX_W  = clog2w(STRING_LEN);
  localparam int LINE_W = clog2w(LINE_NUM);
  localparam int B_WORDS_PER_PIX = CHAN_B / BYTES_PER_WORD;

  // Incoming framing is regenerated, so these are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{sop_i, eop_i, eof_i};

  // ---------------- FIFOs ----------------
  logic [DATA_WIDTH:0] a_dout;
  logic [ACW-1:0]      a_cnt;
  logic                a_pop, a_drop;
  logic [63:0]         b_dout;
  logic [BCW-1:0]      b_cnt;
  logic                b_pop, b_drop;

  sync_fifo_sa #(.WIDTH(DATA_WIDTH + 1), .DEPTH(A_DEPTH), .CW(ACW)) u_a_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (data_valid_i),
    .din_i   ({sof_i, data_i}),
    .pop_i   (a_pop),
    .dout_o  (a_dout),
    .count_o (a_cnt),
    .drop_o  (a_drop)
  );

  sync_fifo_sa #(.WIDTH(64), .DEPTH(B_DEPTH), .CW(BCW)) u_b_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ddr_data_valid),
    .din_i   (ddr_data),
    .pop_i   (b_pop),
    .dout_o  (b_dout),
    .count_o (b_cnt),
    .drop_o  (b_drop)
  );

  // ---------------- state ----------------
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // sample index within current phase
  logic [2:0]          bptr_q, bptr_d;   // byte within current B word
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                vld_q, vld_d;
  logic                sop_q, sop_d, eop_q, eop_d, sof_q, sof_d, eof_q, eof_d;
  logic                a_ovf_q, b_ovf_q, aempty_q;

  logic                a_empty, a_head_sof;
  logic [DATA_WIDTH-1:0] a_head_data;
  logic [7:0]          b_byte;
  logic [BCW-1:0]      b_left;
  logic                pix_rdy, restart, last_b, end_line, end_frame;

  assign a_empty     = (a_cnt == '0);
  assign a_head_sof  = a_dout[DATA_WIDTH];
  assign a_head_data = a_dout[DATA_WIDTH-1:0];
  assign b_byte      = b_dout[{bptr_q, 3'b000} +: 8];

  // B word is released as its last byte goes out. The readiness test at the
  // end of a pixel must not count that departing word.
  assign b_pop   = (state_q == SEND_B) && (bptr_q == 3'd7);
  assign b_left  = b_cnt - BCW'(b_pop);
  assign pix_rdy = (a_cnt >= ACW'(CHAN_A)) && (b_left >= BCW'(B_WORDS_PER_PIX));

  assign last_b    = (cnt_q == CNT_W'(CHAN_B - 1));
  assign end_line  = (pix_q == PIX_W'(STRING_LEN - 1));
  assign end_frame = end_line && (line_q == LINE_W'(LINE_NUM - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bptr_d  = bptr_q;
    pix_d   = pix_q;
    line_d  = line_q;
    a_pop   = 1'b0;
    restart = 1'b0;
    vld_d   = 1'b0;
    data_d  = '0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!a_empty) begin
          if (!a_head_sof) begin
            a_pop = 1'b1;                       // resync: drop untagged head
          end else if (pix_rdy) begin
            state_d = SEND_A;
            cnt_d   = '0;
            pix_d   = '0;
            line_d  = '0;
          end
        end
      end
      SEND_A: begin
        a_pop  = 1'b1;
        vld_d  = 1'b1;
        data_d = a_head_data;
        // A frame-start tag anywhere but (0,0) aborts the frame in flight.
        restart = a_head_sof && ((pix_q != '0) || (line_q != '0));
        if (restart) begin
          pix_d  = '0;
          line_d = '0;
        end
        sop_d = ((cnt_q == '0) && (pix_q == '0)) || restart;
        sof_d = sop_d && ((line_q == '0) || restart);
        if (cnt_q == CNT_W'(CHAN_A - 1)) begin
          cnt_d   = '0;
          state_d = SEND_B;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND_B: begin
        vld_d  = 1'b1;
        data_d = DATA_WIDTH'(b_byte);
        bptr_d = bptr_q + 3'd1;
        eop_d  = last_b && end_line;
        eof_d  = last_b && end_frame;
        if (last_b) begin
          cnt_d = '0;
          if (end_line) begin
            pix_d  = '0;
            line_d = end_frame ? '0 : line_q + LINE_W'(1);
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
          if (end_frame)    state_d = IDLE;
          else if (pix_rdy) state_d = SEND_A;
          else              state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (pix_rdy) state_d = SEND_A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bptr_q   <= '0;
      pix_q    <= '0;
      line_q   <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      a_ovf_q  <= 1'b0;
      b_ovf_q  <= 1'b0;
      aempty_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bptr_q   <= bptr_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      a_ovf_q  <= a_ovf_q | a_drop;
      b_ovf_q  <= b_ovf_q | b_drop;
      aempty_q <= (b_cnt < BCW'(AEMPTY_THR));
    end
  end

  assign data_o          = data_q;
  assign data_valid_o    = vld_q;
  assign sop_o           = sop_q;
  assign eop_o           = eop_q;
  assign sof_o           = sof_q;
  assign eof_o           = eof_q;
  assign a_ovf_o         = a_ovf_q;
  assign b_ovf_o         = b_ovf_q;
  assign ddr_fifo_aempty = aempty_q;

endmodule

// File: tb/tb_skip_concat.sv
module tb_skip_concat;
  localparam int CA = 2, CB = 8, SL = 2, LN = 2;
  localparam int PIXN = CA + CB;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  // main DUT
  logic [7:0]  data_i = '0;
  logic        data_valid_i = 0, sof_i = 0;
  logic [63:0] ddr_data = '0;
  logic        ddr_data_valid = 0;
  logic        ddr_fifo_aempty, data_valid_o, sop_o, eop_o, sof_o, eof_o, a_ovf_o, b_ovf_o;
  logic [7:0]  data_o;

  skip_concat #(.DATA_WIDTH(8), .CHAN_A(CA), .CHAN_B(CB), .STRING_LEN(SL), .LINE_NUM(LN),
                .A_DEPTH(16), .B_DEPTH(8), .AEMPTY_THR(4)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .sop_i(1'b0), .eop_i(1'b0), .sof_i(sof_i), .eof_i(1'b0),
    .ddr_data(ddr_data), .ddr_data_valid(ddr_data_valid), .ddr_fifo_aempty(ddr_fifo_aempty),
    .data_o(data_o), .data_valid_o(data_valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .sof_o(sof_o), .eof_o(eof_o), .a_ovf_o(a_ovf_o), .b_ovf_o(b_ovf_o));

  // small-FIFO DUT for overflow
  logic [7:0]  d2_din = '0;
  logic        d2_vin = 0, d2_sofin = 0;
  logic [63:0] d2_ddr = '0;
  logic        d2_ddr_v = 0;
  logic        d2_aempty, d2_vld, d2_sop, d2_eop, d2_sof, d2_eof, d2_aovf, d2_bovf;
  logic [7:0]  d2_dout;

  skip_concat #(.DATA_WIDTH(8), .CHAN_A(CA), .CHAN_B(CB), .STRING_LEN(SL), .LINE_NUM(LN),
                .A_DEPTH(4), .B_DEPTH(4), .AEMPTY_THR(2)) dut2 (
    .clk(clk), .reset(reset), .data_i(d2_din), .data_valid_i(d2_vin),
    .sop_i(1'b0), .eop_i(1'b0), .sof_i(d2_sofin), .eof_i(1'b0),
    .ddr_data(d2_ddr), .ddr_data_valid(d2_ddr_v), .ddr_fifo_aempty(d2_aempty),
    .data_o(d2_dout), .data_valid_o(d2_vld), .sop_o(d2_sop), .eop_o(d2_eop),
    .sof_o(d2_sof), .eof_o(d2_eof), .a_ovf_o(d2_aovf), .b_ovf_o(d2_bovf));

  typedef struct { logic [7:0] d; logic [3:0] f; int k; } exp_t;  // f = {sop,eop,sof,eof}
  exp_t exp_q[$];

  int nvec = 0, nerr = 0, cyc = 0;
  int cap_n = 0, d2_n = 0;
  logic [7:0] cap_d [0:63];
  logic [3:0] cap_f [0:63];
  int         cap_t [0:63];
  logic [7:0] d2_cap [0:63];
  logic       d2_sof0 = 0;

  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // ---------------- model ----------------
  function automatic logic [63:0] mkword(input logic [7:0] b);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = b + 8'(i);
    return w;
  endfunction

  // One pixel at frame position (x,y): CA A samples then CB bytes of w, low byte first.
  task automatic exp_px(input int x, input int y, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [63:0] w);
    exp_t e;
    logic sop, eop, sof, eof;
    for (int k = 0; k < PIXN; k++) begin
      e.d = (k == 0) ? a0 : (k == 1) ? a1 : w[8*(k-CA) +: 8];
      sop = (k == 0) && (x == 0);
      sof = sop && (y == 0);
      eop = (k == PIXN-1) && (x == SL-1);
      eof = eop && (y == LN-1);
      e.f = {sop, eop, sof, eof};
      e.k = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic exp_frame(input logic [7:0] abase, input logic [7:0] bbase);
    for (int p = 0; p < SL*LN; p++)
      exp_px(p % SL, p / SL, abase + 8'(2*p), abase + 8'(2*p+1), mkword(bbase + 8'(8*p)));
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    bit mid;
    mid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mid = 0;
      end else begin
        if (data_valid_o) begin
          nvec++;
          if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL stream: unexpected sample %0h flags %b, want no output", data_o,
                     {sop_o, eop_o, sof_o, eof_o});
          end else begin
            e = exp_q.pop_front();
            if (data_o !== e.d || {sop_o, eop_o, sof_o, eof_o} !== e.f) begin
              nerr++;
              $display("FAIL stream[%0d]: data %0h flags %b, want data %0h flags %b", cap_n,
                       data_o, {sop_o, eop_o, sof_o, eof_o}, e.d, e.f);
            end
            mid = (e.k != PIXN-1);
          end
          if (cap_n < 64) begin
            cap_d[cap_n] = data_o;
            cap_f[cap_n] = {sop_o, eop_o, sof_o, eof_o};
            cap_t[cap_n] = cyc;
          end
          cap_n++;
        end else if (mid) begin
          nvec++; nerr++;
          $display("FAIL gap: data_valid_o 0 inside a pixel, want 1");
          mid = 0;
        end
        if (d2_vld) begin
          if (d2_n < 64) d2_cap[d2_n] = d2_dout;
          if (d2_n == 0) d2_sof0 = d2_sof;
          d2_n++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick; @(posedge clk); #1; endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic s);
    data_i = d; sof_i = s; data_valid_i = 1; tick; data_valid_i = 0; sof_i = 0;
  endtask

  task automatic push_b(input logic [63:0] w);
    ddr_data = w; ddr_data_valid = 1; tick; ddr_data_valid = 0;
  endtask

  task automatic push_a2(input logic [7:0] d, input logic s);
    d2_din = d; d2_sofin = s; d2_vin = 1; tick; d2_vin = 0; d2_sofin = 0;
  endtask

  task automatic push_b2(input logic [63:0] w);
    d2_ddr = w; d2_ddr_v = 1; tick; d2_ddr_v = 0;
  endtask

  task automatic drain(input string nm, input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin tick; n++; end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s timeout: %0d samples outstanding, want 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick;
  endtask

  task automatic run_basic(input string nm);
    cap_n = 0;
    for (int i = 0; i < 4; i++) push_b(mkword(8'(8*i)));
    tick;
    chk({nm, "_aempty_full"}, ddr_fifo_aempty, 0);
    exp_frame(8'hA0, 8'h00);
    for (int i = 0; i < 8; i++) push_a(8'hA0 + 8'(i), i == 0);
    drain(nm, 300);
    chk({nm, "_count"}, cap_n, 40);
    chk({nm, "_s0"}, {cap_d[0], cap_f[0]}, {8'hA0, 4'b1010});
    chk({nm, "_s1"}, cap_d[1], 8'hA1);
    chk({nm, "_s2"}, cap_d[2], 8'h00);
    chk({nm, "_s9"}, cap_d[9], 8'h07);
    chk({nm, "_s10"}, cap_d[10], 8'hA2);
    chk({nm, "_s19"}, {cap_d[19], cap_f[19]}, {8'h0F, 4'b0100});
    chk({nm, "_s39"}, {cap_d[39], cap_f[39]}, {8'h1F, 4'b0101});
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n;
    reset = 1;
    tick; tick;
    reset = 0;
    @(negedge clk);
    chk("reset_state", {data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, a_ovf_o, b_ovf_o,
                        ddr_fifo_aempty}, 0);
    @(negedge clk);
    chk("aempty_after_reset", ddr_fifo_aempty, 1);
    tick;

    run_basic("basic");

    // B starvation: words trickle in, FSM waits between pixels only
    cap_n = 0;
    exp_frame(8'hB0, 8'h20);
    for (int i = 0; i < 8; i++) push_a(8'hB0 + 8'(i), i == 0);
    for (int i = 0; i < 4; i++) begin
      repeat (20) begin tick; chk("starve_aempty", ddr_fifo_aempty, 1); end
      push_b(mkword(8'h20 + 8'(8*i)));
    end
    drain("starve", 300);
    chk("starve_gap", (cap_t[10] - cap_t[9]) > 1, 1);

    // resync: untagged A heads are discarded
    for (int i = 0; i < 4; i++) push_b(mkword(8'h40 + 8'(8*i)));
    exp_frame(8'hC3, 8'h40);
    for (int i = 0; i < 11; i++) push_a(8'hC0 + 8'(i), i == 3);
    drain("resync", 300);
    chk("resync_ovf", {a_ovf_o, b_ovf_o}, 0);

    // mid-frame sof on third pixel restarts counters, no eof for aborted frame
    for (int i = 0; i < 6; i++) push_b(mkword(8'h60 + 8'(8*i)));
    exp_px(0, 0, 8'hE0, 8'hE1, mkword(8'h60));
    exp_px(1, 0, 8'hE2, 8'hE3, mkword(8'h68));
    exp_px(0, 0, 8'hE4, 8'hE5, mkword(8'h70));
    exp_px(1, 0, 8'hE6, 8'hE7, mkword(8'h78));
    exp_px(0, 1, 8'hE8, 8'hE9, mkword(8'h80));
    exp_px(1, 1, 8'hEA, 8'hEB, mkword(8'h88));
    for (int i = 0; i < 12; i++) push_a(8'hE0 + 8'(i), (i == 0) || (i == 4));
    drain("midsof", 300);

    // overflow on the small-FIFO instance
    d2_n = 0;
    for (int i = 0; i < 6; i++) begin
      push_a2(8'h61 + 8'(i), i == 0);
      if (i == 3) chk("a_ovf_at4", d2_aovf, 0);
      if (i == 4) chk("a_ovf_at5", d2_aovf, 1);
    end
    for (int i = 0; i < 5; i++) begin
      push_b2(mkword(8'(8*i)));
      if (i == 3) chk("b_ovf_at4", d2_bovf, 0);
      if (i == 4) chk("b_ovf_at5", d2_bovf, 1);
    end
    repeat (60) tick;
    chk("ovf_out_count", d2_n, 20);
    chk("ovf_s0", {d2_cap[0], d2_sof0}, {8'h61, 1'b1});
    chk("ovf_s2", d2_cap[2], 8'h00);
    chk("ovf_s10", {d2_cap[10], d2_cap[11]}, {8'h63, 8'h64});

    // reset mid-pixel while in SEND_B
    cap_n = 0;
    for (int i = 0; i < 4; i++) push_b(mkword(8'h90 + 8'(8*i)));
    exp_frame(8'hD0, 8'h90);
    for (int i = 0; i < 8; i++) push_a(8'hD0 + 8'(i), i == 0);
    n = 0;
    while (cap_n < 13 && n < 200) begin tick; n++; end
    chk("pre_reset_progress", cap_n >= 13, 1);
    reset = 1;
    exp_q.delete();
    tick;
    reset = 0;
    @(negedge clk);
    chk("midreset_state", {data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, a_ovf_o, b_ovf_o,
                           ddr_fifo_aempty}, 0);
    chk("midreset_flags2", {d2_aovf, d2_bovf}, 0);
    tick;
    run_basic("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
